// File: rtl/dct8_mac_sequencer.sv
// dct8_mac_sequencer
// 8-point 1D DCT, X[k] = sum_n x[n]*C[k][n], computed with one shared Q1.15
// multiplier over 64 MAC cycles. Samples arrive serially and coefficients
// leave serially, both over valid/ready handshakes.
//
// Build option: define DCT_SAT_EN to saturate the shifted accumulator to
// 16 bits. Without it, out_data is the low 16 bits of the shifted
// accumulator (two's-complement wrap).
module dct8_mac_sequencer #(
  parameter int ACC_W     = 20,
  parameter int OUT_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_idx,
  output logic        busy
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

`ifdef DCT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);
`endif

  // Cosine ROM: C[k][n] = round(16384 * cos((2n+1)*k*pi/16)) for k > 0 and
  // 11585 for k = 0. The angle index m = (2n+1)*k mod 32 is folded onto the
  // first quadrant so only nine magnitudes need storing.
  function automatic logic signed [15:0] coef_lookup(input logic [2:0] k,
                                                     input logic [2:0] n);
    logic [4:0]  m;
    logic [3:0]  idx;
    logic        neg;
    logic [15:0] mag;
    m = {1'b0, n, 1'b1} * {2'b00, k};
    if (m <= 5'd8) begin
      idx = m[3:0];
      neg = 1'b0;
    end else if (m <= 5'd16) begin
      idx = 4'(5'd16 - m);
      neg = 1'b1;
    end else if (m <= 5'd24) begin
      idx = 4'(m - 5'd16);
      neg = 1'b1;
    end else begin
      idx = 4'(6'd32 - {1'b0, m});
      neg = 1'b0;
    end
    case (idx)
      4'd0:    mag = 16'd16384;
      4'd1:    mag = 16'd16069;
      4'd2:    mag = 16'd15137;
      4'd3:    mag = 16'd13623;
      4'd4:    mag = 16'd11585;
      4'd5:    mag = 16'd9102;
      4'd6:    mag = 16'd6270;
      4'd7:    mag = 16'd3196;
      4'd8:    mag = 16'd0;
      default: mag = 16'd0;
    endcase
    if (k == 3'd0) begin
      coef_lookup = 16'sd11585;
    end else if (neg) begin
      coef_lookup = -$signed(mag);
    end else begin
      coef_lookup = $signed(mag);
    end
  endfunction

  logic [1:0]              state_r;
  logic [2:0]              cnt_r;
  logic [2:0]              k_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [15:0]             x_r [0:7];
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic                    busy_r;
  logic [15:0]             out_data_r;
  logic [2:0]              out_idx_r;

  logic signed [15:0]      coef_s;
  logic signed [31:0]      prod_s;
  logic signed [15:0]      p_s;
  logic signed [ACC_W-1:0] p_ext_s;
  logic signed [ACC_W-1:0] acc_next_s;
  logic signed [ACC_W-1:0] shifted_s;
  logic [15:0]             out_next_s;

  // Shared multiplier, accumulator update and output reduction.
  always_comb begin
    coef_s  = coef_lookup(k_r, cnt_r);
    prod_s  = $signed({{16{x_r[cnt_r][15]}}, x_r[cnt_r]}) *
              $signed({{16{coef_s[15]}}, coef_s});
    p_s     = 16'(prod_s >>> 15);
    p_ext_s = {{(ACC_W-16){p_s[15]}}, p_s};
    if (cnt_r == 3'd0) begin
      acc_next_s = p_ext_s;
    end else begin
      acc_next_s = acc_r + p_ext_s;
    end
    shifted_s = acc_next_s >>> OUT_SHIFT;
`ifdef DCT_SAT_EN
    if (shifted_s > SAT_MAX) begin
      out_next_s = 16'h7FFF;
    end else if (shifted_s < SAT_MIN) begin
      out_next_s = 16'h8000;
    end else begin
      out_next_s = 16'(shifted_s);
    end
`else
    out_next_s = 16'(shifted_s);
`endif
  end

  // Sequencer: load eight samples, run eight MACs per k, hold each result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_LOAD;
      cnt_r       <= 3'd0;
      k_r         <= 3'd0;
      acc_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= 16'd0;
      out_idx_r   <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        x_r[i] <= 16'd0;
      end
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (in_valid && in_ready_r) begin
            x_r[cnt_r] <= in_data;
            cnt_r      <= cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
              k_r        <= 3'd0;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b1;
              state_r    <= ST_MAC;
            end
          end
        end
        ST_MAC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            out_data_r  <= out_next_s;
            out_idx_r   <= k_r;
            out_valid_r <= 1'b1;
            state_r     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (k_r == 3'd7) begin
              k_r        <= 3'd0;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b0;
              state_r    <= ST_LOAD;
            end else begin
              k_r     <= k_r + 3'd1;
              state_r <= ST_MAC;
            end
          end
        end
        default: begin
          state_r     <= ST_LOAD;
          cnt_r       <= 3'd0;
          k_r         <= 3'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dct8_mac_sequencer.sv
// Testbench for dct8_mac_sequencer: table of directed blocks, backpressure,
// mid-operation reset and randomized blocks, all checked against a
// floating-point cosine reference model with integer Q1.15 arithmetic.
module tb_dct8_mac_sequencer;

  localparam int ACC_W     = 20;
  localparam int OUT_SHIFT = 0;

  typedef logic [7:0][15:0] blk_t;

  typedef struct {
    blk_t xs;
    int   x0;
    bit   chk_x1;
    int   x1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dct8_mac_sequencer #(.ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DCT basis value from the defining formula.
  function automatic int cref(input int k, input int n);
    real c;
    real v;
    c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v = 32768.0 * c / 2.0 * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Expected X[k]: floored Q1.15 products, ACC_W-bit accumulator, shift, reduce.
  function automatic int model_x(input blk_t xs, input int k);
    longint s;
    longint p;
    s = 0;
    for (int n = 0; n < 8; n++) begin
      p = longint'($signed(xs[n])) * longint'(cref(k, n));
      s = s + (p >>> 15);
    end
    s = s & ((64'sd1 <<< ACC_W) - 1);
    if (s >= (64'sd1 <<< (ACC_W - 1))) s = s - (64'sd1 <<< ACC_W);
    s = s >>> OUT_SHIFT;
`ifdef DCT_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`else
    s = s & 64'sd65535;
    if (s >= 32768) s = s - 65536;
`endif
    return int'(s);
  endfunction

  task automatic load_block(input blk_t xs);
    for (int i = 0; i < 8; i++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) check("load_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = xs[i];
    end
  endtask

  task automatic take_outputs(input blk_t xs, input int nk, input int stall_k,
                              input int stall_n, input bit junk,
                              input bit chk_x0, input int x0,
                              input bit chk_x1, input int x1);
    for (int k = 0; k < nk; k++) begin
      int w;
      bit ready_bad;
      bit busy_bad;
      w = 0;
      ready_bad = 1'b0;
      busy_bad  = 1'b0;
      do begin
        @(negedge clk);
        w++;
        in_valid = junk;
        in_data  = 16'($urandom);
        if (in_ready) ready_bad = 1'b1;
        if (!busy) busy_bad = 1'b1;
      end while (!out_valid && w < 40);
      check("latency", w, 9);
      check("in_ready_low", ready_bad, 0);
      check("busy_high", busy_bad, 0);
      check("out_idx", out_idx, k);
      check("out_data", $signed(out_data), model_x(xs, k));
      if (k == 0 && chk_x0) check("x0_const", $signed(out_data), x0);
      if (k == 1 && chk_x1) check("x1_const", $signed(out_data), x1);
      if (k == nk - 1) in_valid = 1'b0;
      if (k == stall_k) begin
        logic [15:0] hd;
        logic [2:0]  hi;
        bit          bad;
        hd  = out_data;
        hi  = out_idx;
        bad = 1'b0;
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          in_valid = junk && (k != nk - 1);
          in_data  = 16'($urandom);
          if (!out_valid || out_data != hd || out_idx != hi || in_ready) bad = 1'b1;
        end
        check("backpressure_hold", bad, 0);
        if (k == nk - 1) in_valid = 1'b0;
        out_ready = 1'b1;
      end
    end
  endtask

  task automatic done_check();
    @(negedge clk);
    check("end_in_ready", in_ready, 1);
    check("end_busy", busy, 0);
    check("end_out_valid", out_valid, 0);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    blk_t b;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b1;

    for (int i = 0; i < 8; i++) begin
      tbl[0].xs[i] = 16'h1000;
      tbl[1].xs[i] = (i == 0) ? 16'h7FFF : 16'h0000;
      tbl[2].xs[i] = 16'h4000;
      tbl[3].xs[i] = 16'h0000;
      tbl[4].xs[i] = (i == 0) ? 16'h8000 : 16'h0000;
      tbl[5].xs[i] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
    end
    tbl[0].x0 = 11584;  tbl[0].chk_x1 = 1'b0; tbl[0].x1 = 0;
    tbl[1].x0 = 11584;  tbl[1].chk_x1 = 1'b1; tbl[1].x1 = 16068;
`ifdef DCT_SAT_EN
    tbl[2].x0 = 32767;
`else
    tbl[2].x0 = -19200;
`endif
    tbl[2].chk_x1 = 1'b0; tbl[2].x1 = 0;
    tbl[3].x0 = 0;      tbl[3].chk_x1 = 1'b1; tbl[3].x1 = 0;
    tbl[4].x0 = -11585; tbl[4].chk_x1 = 1'b1; tbl[4].x1 = -16069;
    tbl[5].x0 = -4;     tbl[5].chk_x1 = 1'b0; tbl[5].x1 = 0;

    repeat (3) @(negedge clk);
    reset_check("reset");
    rst_n = 1'b1;

    // Directed table of blocks, out_ready held high.
    for (int v = 0; v < 6; v++) begin
      load_block(tbl[v].xs);
      take_outputs(tbl[v].xs, 8, -1, 0, 1'b0, 1'b1, tbl[v].x0,
                   tbl[v].chk_x1, tbl[v].x1);
      done_check();
    end

    // Backpressure: out_ready low for 5 cycles while k=2 is presented.
    load_block(tbl[0].xs);
    take_outputs(tbl[0].xs, 8, 2, 5, 1'b0, 1'b1, 11584, 1'b0, 0);
    done_check();

    // Reset while the k=3 MAC pass is running.
    for (int i = 0; i < 8; i++) b[i] = 16'($urandom);
    load_block(b);
    take_outputs(b, 3, -1, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 reset_check("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    load_block(tbl[1].xs);
    take_outputs(tbl[1].xs, 8, -1, 0, 1'b0, 1'b1, 11584, 1'b1, 16068);
    done_check();

    // Random blocks with junk input during MAC/OUT and a random stall.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) b[i] = 16'($urandom);
      load_block(b);
      take_outputs(b, 8, int'($urandom_range(0, 7)), int'($urandom_range(1, 6)),
                   1'b1, 1'b0, 0, 1'b0, 0);
      done_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
